// File: rtl/cpc_iowr_capture_if.sv
// Bus-side bundle for the CPC I/O-write capture stage.
// The Z80 drives the raw bus fields. The capture stage returns the registered ROM-select and MRER state.
interface cpc_iowr_capture_if;
    logic       adr15;
    logic       adr14;
    logic       adr13;
    logic       ioreq_b;
    logic       wr_b;
    logic [7:0] data;
    logic [7:0] romsel_q;
    logic       romsel_stb;
    logic       lrom_dis_q;
    logic       urom_dis_q;
    logic [1:0] mode_q;
    logic       mrer_stb;

    // capture stage side
    modport slave (
        input  adr15, adr14, adr13, ioreq_b, wr_b, data,
        output romsel_q, romsel_stb, lrom_dis_q, urom_dis_q, mode_q, mrer_stb
    );

    // bus driver / consumer side
    modport master (
        output adr15, adr14, adr13, ioreq_b, wr_b, data,
        input  romsel_q, romsel_stb, lrom_dis_q, urom_dis_q, mode_q, mrer_stb
    );
endinterface

// File: rtl/cpc_iowr_capture.sv
// Z80 I/O-write capture for the CPC expansion bus.
// The stage synchronises the raw control and address lines and decodes the ROM-select port (A15..13 = 110)
// and the gate-array MRER port (A15..14 = 01, data[7:6] = 10).
// A write is captured only once it has been seen for SETTLE consecutive cycles. Only one capture is made per bus write.
// Data is sampled raw on the capture edge; the Z80 holds it stable while WR is low.
// Legal SETTLE range is 1..15.
module cpc_iowr_capture #(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              reset_b,
    cpc_iowr_capture_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
    // sync vector layout: {a15, a14, a13, ioreq_b, wr_b}; the strobes idle high
    localparam logic [4:0] SYNC_RST   = 5'b00011;

    logic [4:0] w_raw;
    logic [4:0] r_s1;
    logic [4:0] r_s2;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_tgt;          // 0 = ROM-select, 1 = gate array
    logic       w_tgt_next;

    logic       w_wrs;
    logic       w_bus_idle;
    logic       w_hit_rom;
    logic       w_hit_ga;
    logic       w_tgt_hit;
    logic       w_settled;
    logic       w_cap_rom;
    logic       w_cap_ga;

    logic [7:0] r_romsel_q;
    logic       r_romsel_stb;
    logic       r_lrom_dis;
    logic       r_urom_dis;
    logic [1:0] r_mode;
    logic       r_mrer_stb;

    assign w_raw = {bus.adr15, bus.adr14, bus.adr13, bus.ioreq_b, bus.wr_b};

    // two-flop synchroniser on address and control lines (data is deliberately left raw)
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_s1 <= SYNC_RST;
            r_s2 <= SYNC_RST;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    assign w_wrs      = ~r_s2[1] & ~r_s2[0];
    assign w_bus_idle =  r_s2[1] &  r_s2[0];
    assign w_hit_rom  = w_wrs &  r_s2[4] & r_s2[3] & ~r_s2[2];
    assign w_hit_ga   = w_wrs & ~r_s2[4] & r_s2[3];
    assign w_tgt_hit  = r_tgt ? w_hit_ga : w_hit_rom;
    assign w_settled  = (r_cnt == SETTLE_CNT);

    // FSM state, settle counter and latched target
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_tgt   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tgt   <= w_tgt_next;
        end
    end

    // next-state: start counting on a decode hit, abort if it drops, park in HOLD until the bus releases
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_tgt_next   = r_tgt;
        case (r_state)
            ST_IDLE: begin
                if (w_hit_rom | w_hit_ga) begin
                    w_state_next = ST_COUNT;
                    w_cnt_next   = 4'd1;
                    w_tgt_next   = w_hit_ga;
                end
            end
            ST_COUNT: begin
                if (!w_tgt_hit) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = 4'd0;
                end else if (w_settled) begin
                    w_state_next = ST_HOLD;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt + 4'd1;
                end
            end
            ST_HOLD: begin
                if (w_bus_idle) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // capture enables; a gate-array write whose data is not an MRER command is consumed without effect
    always_comb begin
        w_cap_rom = 1'b0;
        w_cap_ga  = 1'b0;
        if (r_state == ST_COUNT && w_tgt_hit && w_settled) begin
            w_cap_rom = ~r_tgt;
            w_cap_ga  = r_tgt & (bus.data[7:6] == 2'b10);
        end
    end

    // registered outputs and single-cycle update strobes
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_romsel_q   <= 8'h00;
            r_romsel_stb <= 1'b0;
            r_lrom_dis   <= 1'b0;
            r_urom_dis   <= 1'b0;
            r_mode       <= 2'b00;
            r_mrer_stb   <= 1'b0;
        end else begin
            r_romsel_stb <= w_cap_rom;
            r_mrer_stb   <= w_cap_ga;
            if (w_cap_rom) begin
                r_romsel_q <= bus.data;
            end
            if (w_cap_ga) begin
                r_lrom_dis <= bus.data[2];
                r_urom_dis <= bus.data[3];
                r_mode     <= bus.data[1:0];
            end
        end
    end

    assign bus.romsel_q   = r_romsel_q;
    assign bus.romsel_stb = r_romsel_stb;
    assign bus.lrom_dis_q = r_lrom_dis;
    assign bus.urom_dis_q = r_urom_dis;
    assign bus.mode_q     = r_mode;
    assign bus.mrer_stb   = r_mrer_stb;
endmodule

// File: tb/tb_cpc_iowr_capture.sv
// Testbench for cpc_iowr_capture.
// Two instances, with SETTLE=1 and SETTLE=2, see identical bus traffic.
// A transaction-level model predicts the capture edge of every bus write and the data sampled there.
module tb_cpc_iowr_capture;
    logic       clk     = 1'b0;
    logic       reset_b = 1'b0;
    logic       t_a15 = 1'b0, t_a14 = 1'b0, t_a13 = 1'b0, t_io = 1'b1, t_wr = 1'b1;
    logic [7:0] t_data = 8'h00;
    int         edge_n = 0;
    int         n_cmp  = 0;
    int         n_mis  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    cpc_iowr_capture_if bus_a ();
    cpc_iowr_capture_if bus_b ();

    assign bus_a.adr15 = t_a15;  assign bus_b.adr15 = t_a15;
    assign bus_a.adr14 = t_a14;  assign bus_b.adr14 = t_a14;
    assign bus_a.adr13 = t_a13;  assign bus_b.adr13 = t_a13;
    assign bus_a.ioreq_b = t_io; assign bus_b.ioreq_b = t_io;
    assign bus_a.wr_b = t_wr;    assign bus_b.wr_b = t_wr;
    assign bus_a.data = t_data;  assign bus_b.data = t_data;

    cpc_iowr_capture #(.SETTLE(1)) dut_a (.clk(clk), .reset_b(reset_b), .bus(bus_a));
    cpc_iowr_capture #(.SETTLE(2)) dut_b (.clk(clk), .reset_b(reset_b), .bus(bus_b));

    logic [7:0] act_romsel [2];
    logic       act_rstb [2], act_lrom [2], act_urom [2], act_mstb [2];
    logic [1:0] act_mode [2];
    assign act_romsel[0] = bus_a.romsel_q;   assign act_romsel[1] = bus_b.romsel_q;
    assign act_rstb[0]   = bus_a.romsel_stb; assign act_rstb[1]   = bus_b.romsel_stb;
    assign act_lrom[0]   = bus_a.lrom_dis_q; assign act_lrom[1]   = bus_b.lrom_dis_q;
    assign act_urom[0]   = bus_a.urom_dis_q; assign act_urom[1]   = bus_b.urom_dis_q;
    assign act_mode[0]   = bus_a.mode_q;     assign act_mode[1]   = bus_b.mode_q;
    assign act_mstb[0]   = bus_a.mrer_stb;   assign act_mstb[1]   = bus_b.mrer_stb;

    // model state
    int         settle_of [2] = '{1, 2};
    logic [7:0] m_romsel [2];
    logic       m_lrom [2], m_urom [2];
    logic [1:0] m_mode [2];
    int         ev [int];            // key edge*2+inst -> 1 ROM capture, 2 GA capture
    logic [7:0] data_hist [int];     // raw data present at each rising edge
    int         rom_stb_cnt [2] = '{0, 0};
    int         mrer_stb_cnt [2] = '{0, 0};
    int         last_rom_edge [2] = '{-1, -1};
    int         last_mrer_edge [2] = '{-1, -1};

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s inst%0d @edge %0d: got %0h, expected %0h", name, inst, edge_n, act, exp);
        end
    endtask

    // per-cycle comparison of both instances against the model
    task automatic compare_cycle();
        logic [7:0] d;
        logic       exp_r, exp_m;
        int         key;
        if (!reset_b) begin
            ev.delete();
            for (int i = 0; i < 2; i++) begin
                m_romsel[i] = 8'h00; m_lrom[i] = 1'b0; m_urom[i] = 1'b0; m_mode[i] = 2'b00;
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_r = 1'b0;
            exp_m = 1'b0;
            key   = edge_n * 2 + i;
            if (reset_b && ev.exists(key)) begin
                d = data_hist.exists(edge_n) ? data_hist[edge_n] : 8'h00;
                if (ev[key] == 1) begin
                    m_romsel[i] = d;
                    exp_r = 1'b1;
                end else if (d[7:6] == 2'b10) begin
                    m_lrom[i] = d[2];
                    m_urom[i] = d[3];
                    m_mode[i] = d[1:0];
                    exp_m = 1'b1;
                end
                ev.delete(key);
            end
            check("romsel_q",   i, 32'(act_romsel[i]), 32'(m_romsel[i]));
            check("romsel_stb", i, 32'(act_rstb[i]),   32'(exp_r));
            check("lrom_dis_q", i, 32'(act_lrom[i]),   32'(m_lrom[i]));
            check("urom_dis_q", i, 32'(act_urom[i]),   32'(m_urom[i]));
            check("mode_q",     i, 32'(act_mode[i]),   32'(m_mode[i]));
            check("mrer_stb",   i, 32'(act_mstb[i]),   32'(exp_m));
            if (act_rstb[i] === 1'b1) begin rom_stb_cnt[i]++;  last_rom_edge[i]  = edge_n; end
            if (act_mstb[i] === 1'b1) begin mrer_stb_cnt[i]++; last_mrer_edge[i] = edge_n; end
        end
    endtask

    // one bus cycle: compare what the last edge produced, then present inputs for the next edge
    task automatic drive_cycle(input logic a15, a14, a13, io, wr, input logic [7:0] d);
        @(negedge clk);
        compare_cycle();
        t_a15 = a15; t_a14 = a14; t_a13 = a13; t_io = io; t_wr = wr; t_data = d;
        data_hist[edge_n + 1] = d;
    endtask

    // idle bus: random address, strobes released, data held unless rnd is set
    task automatic idle(input int n, input bit rnd);
        for (int c = 0; c < n; c++)
            drive_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1,
                        rnd ? 8'($urandom) : t_data);
    endtask

    // one Z80 bus cycle held for len edges, followed by gap idle edges with data held
    task automatic do_txn(input logic a15, a14, a13, io, wr, input logic [7:0] d,
                          input int len, input int gap, input bit sched, output int k);
        k = 0;
        for (int c = 0; c < len; c++) begin
            drive_cycle(a15, a14, a13, io, wr, d);
            if (c == 0) begin
                k = edge_n + 1;
                for (int i = 0; i < 2; i++) begin
                    if (sched && !io && !wr && len >= settle_of[i] + 1) begin
                        if (a15 && a14 && !a13)  ev[(k + 2 + settle_of[i]) * 2 + i] = 1;
                        else if (!a15 && a14)    ev[(k + 2 + settle_of[i]) * 2 + i] = 2;
                    end
                end
            end
        end
        idle(gap, 1'b0);
    endtask

    initial begin
        int k, r0, r1, m0, typ, len, gap, sel;
        logic a15, a14, a13, io, wr;
        logic [7:0] d;

        // reset then idle bus
        idle(3, 1'b1);
        reset_b = 1'b1;
        idle(100, 1'b1);
        check("idle_rom_strobes",  0, 32'(rom_stb_cnt[0] + rom_stb_cnt[1]), 32'd0);
        check("idle_mrer_strobes", 0, 32'(mrer_stb_cnt[0] + mrer_stb_cnt[1]), 32'd0);
        check("idle_romsel", 0, 32'(act_romsel[0]), 32'h00);

        // OUT &DF00,&07 with WR low 3 cycles
        r0 = rom_stb_cnt[0]; r1 = rom_stb_cnt[1];
        do_txn(1, 1, 0, 0, 0, 8'h07, 3, 4, 1'b1, k);
        check("out07_edge_s1", 0, 32'(last_rom_edge[0]), 32'(k + 3));
        check("out07_edge_s2", 1, 32'(last_rom_edge[1]), 32'(k + 4));
        check("out07_count",   0, 32'(rom_stb_cnt[0] - r0), 32'd1);
        check("out07_value",   0, 32'(act_romsel[0]), 32'h07);
        check("out07_mrer",    0, 32'({act_lrom[0], act_urom[0], act_mode[0]}), 32'd0);

        // MRER writes and a palette write
        m0 = mrer_stb_cnt[0];
        do_txn(0, 1, 1, 0, 0, 8'h8C, 3, 4, 1'b1, k);
        check("mrer8c_fields", 0, 32'({act_lrom[0], act_urom[0], act_mode[0]}), 32'b1100);
        check("mrer8c_count",  0, 32'(mrer_stb_cnt[0] - m0), 32'd1);
        do_txn(0, 1, 1, 0, 0, 8'h89, 3, 4, 1'b1, k);
        check("mrer89_fields", 0, 32'({act_lrom[0], act_urom[0], act_mode[0]}), 32'b0101);
        m0 = mrer_stb_cnt[0];
        do_txn(0, 1, 1, 0, 0, 8'h4C, 3, 4, 1'b1, k);
        check("pal4c_count",  0, 32'(mrer_stb_cnt[0] - m0), 32'd0);
        check("pal4c_fields", 0, 32'({act_lrom[0], act_urom[0], act_mode[0]}), 32'b0101);

        // 1-cycle glitch, then the same write held 6 cycles (SETTLE=2 instance)
        r0 = rom_stb_cnt[0]; r1 = rom_stb_cnt[1];
        do_txn(1, 1, 0, 0, 0, 8'h33, 1, 4, 1'b1, k);
        check("glitch_count_s2", 1, 32'(rom_stb_cnt[1] - r1), 32'd0);
        check("glitch_count_s1", 0, 32'(rom_stb_cnt[0] - r0), 32'd0);
        check("glitch_value_s2", 1, 32'(act_romsel[1]), 32'h07);
        do_txn(1, 1, 0, 0, 0, 8'h33, 6, 4, 1'b1, k);
        check("held6_edge_s2",  1, 32'(last_rom_edge[1]), 32'(k + 4));
        check("held6_count_s2", 1, 32'(rom_stb_cnt[1] - r1), 32'd1);
        check("held6_value_s2", 1, 32'(act_romsel[1]), 32'h33);

        // long WR, then back-to-back after a 2-cycle release
        r0 = rom_stb_cnt[0]; r1 = rom_stb_cnt[1];
        do_txn(1, 1, 0, 0, 0, 8'h05, 20, 2, 1'b1, k);
        check("long_count_s1", 0, 32'(rom_stb_cnt[0] - r0), 32'd1);
        check("long_count_s2", 1, 32'(rom_stb_cnt[1] - r1), 32'd1);
        check("long_value",    0, 32'(act_romsel[0]), 32'h05);
        do_txn(1, 1, 0, 0, 0, 8'h0A, 3, 4, 1'b1, k);
        check("b2b_value_s1", 0, 32'(act_romsel[0]), 32'h0A);
        check("b2b_value_s2", 1, 32'(act_romsel[1]), 32'h0A);

        // reset pulsed while both instances are counting
        r0 = rom_stb_cnt[0]; r1 = rom_stb_cnt[1];
        for (int c = 0; c < 3; c++) drive_cycle(1, 1, 0, 0, 0, 8'hEE);
        @(posedge clk);
        #2 reset_b = 1'b0;
        #1;
        check("async_rst_romsel_s1", 0, 32'(act_romsel[0]), 32'h00);
        check("async_rst_romsel_s2", 1, 32'(act_romsel[1]), 32'h00);
        check("async_rst_mrer", 0, 32'({act_lrom[0], act_urom[0], act_mode[0]}), 32'd0);
        check("async_rst_stb",  0, 32'({act_rstb[0], act_mstb[0], act_rstb[1], act_mstb[1]}), 32'd0);
        idle(2, 1'b1);
        reset_b = 1'b1;
        idle(4, 1'b1);
        check("rst_no_stb", 0, 32'(rom_stb_cnt[0] + rom_stb_cnt[1] - r0 - r1), 32'd0);
        do_txn(1, 1, 0, 0, 0, 8'h5A, 4, 4, 1'b1, k);
        check("post_rst_value", 0, 32'(act_romsel[0]), 32'h5A);

        // randomized bus traffic
        for (int t = 0; t < 300; t++) begin
            typ = $urandom_range(0, 5);
            d   = 8'($urandom);
            len = ($urandom_range(0, 7) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 6);
            gap = $urandom_range(1, 4);
            a15 = 1'b1; a14 = 1'b1; a13 = 1'b0; io = 1'b0; wr = 1'b0;
            case (typ)
                0: ;
                1: begin
                    a15 = 1'b0; a13 = 1'($urandom);
                    if ($urandom_range(0, 1) == 1) d[7:6] = 2'b10;
                end
                2: begin
                    sel = $urandom_range(0, 2);
                    if (sel == 0)      begin a14 = 1'b0; a13 = 1'($urandom); end
                    else if (sel == 1) begin a13 = 1'b1; end
                    else               begin a15 = 1'b0; a14 = 1'b0; a13 = 1'($urandom); end
                end
                3, 5: begin wr = 1'b1; a15 = 1'($urandom); a13 = 1'($urandom); end
                default: begin io = 1'b1; a15 = 1'($urandom); a13 = 1'($urandom); end
            endcase
            do_txn(a15, a14, a13, io, wr, d, len, gap, 1'b1, k);
        end
        idle(10, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/cpc_iowr_capture.md
Name: cpc_iowr_capture

Overview:
- Synchronous Z80 I/O-write capture stage on the CPC expansion bus.
- Samples the raw bus on the CPU clock, filters glitches and decodes two ports:
  - ROM-select port: A15=1, A14=1, A13=0.
  - Gate-array MRER port: A15=0, A14=1, with data[7:6]=2'b10.
- Registers the ROM number and the lower/upper ROM disable flags with one-cycle update strobes.
- Directly upstream of the six-socket ROM decoder, which consumes romsel_q and the disable flags.

Parameters:
SETTLE, 1, consecutive synchronised cycles a decoded write must persist before capture (legal 1..15).

Ports:
clk  input  1  CPC CPU clock (4 MHz); all state on rising edge
reset_b  input  1  asynchronous active-low reset
adr15  input  1  Z80 A15, raw
adr14  input  1  Z80 A14, raw
adr13  input  1  Z80 A13, raw
ioreq_b  input  1  Z80 IORQ, active low, raw
wr_b  input  1  Z80 WR, active low, raw
data  input  8  Z80 data bus, raw
romsel_q  output  8  last byte written to ROM-select port
romsel_stb  output  1  one-cycle pulse when romsel_q updates
lrom_dis_q  output  1  MRER bit 2: lower ROM disabled
urom_dis_q  output  1  MRER bit 3: upper ROM disabled
mode_q  output  2  MRER bits 1:0 (screen mode, informational)
mrer_stb  output  1  one-cycle pulse when MRER fields update

Behaviour:
- Reset (async, reset_b low) forces the following; every output is registered:
  - romsel_q=8'h00, romsel_stb=0, mrer_stb=0.
  - lrom_dis_q=0, urom_dis_q=0, mode_q=2'b00.
  - FSM=IDLE, cnt=0.
  - Sync flops: ioreq_b and wr_b to 1, address bits to 0.
- Reset asserted mid-write abandons the write. No strobe is issued.
- Synchronisers:
  - adr15/14/13, ioreq_b and wr_b each pass through 2 flops (s1, s2).
  - data is not synchronised. It is sampled raw on the capture edge; Z80 holds data stable for the whole WR-low window.
- Decode on s2 values, with wrs = !ioreq_s2 & !wr_s2:
  - hit_rom = wrs & a15 & a14 & !a13.
  - hit_ga = wrs & !a15 & a14.
  - The two hits are mutually exclusive by construction.
- FSM states IDLE, COUNT, HOLD.
  - IDLE:
    - hit_rom or hit_ga → COUNT, cnt=1, latch tgt (0=ROM, 1=GA).
  - COUNT:
    - If the hit matching tgt is false (glitch, or the address changed) → IDLE, no update.
    - Else if cnt==SETTLE → capture and go to HOLD.
      - tgt=ROM: romsel_q<=data, romsel_stb=1 for the next cycle.
      - tgt=GA with data[7:6]==2'b10: lrom_dis_q<=data[2], urom_dis_q<=data[3], mode_q<=data[1:0], mrer_stb=1.
      - tgt=GA with any other data[7:6]: no register change, no strobe. It still goes to HOLD.
    - Else cnt<=cnt+1.
  - HOLD:
    - Wait until ioreq_s2=1 and wr_s2=1 → IDLE.
    - Exactly one capture per bus write, however long WR stays low.
- Latency: raw ioreq_b/wr_b low and address valid before rising edge k gives:
  - capture on edge k+2+SETTLE;
  - strobe high in the cycle following that edge.
  - SETTLE=1 → capture edge k+3.
- Strobes are high for exactly one clk cycle and never both high together.
- Back-to-back OUTs are separated by at least one synchronised deassert (HOLD→IDLE) before the next write is accepted.
- A write that releases before cnt reaches SETTLE is dropped silently.
- Reads (wr_b high), memory cycles and interrupt acknowledge (IORQ without WR) are ignored.

Test Plan:
- Reset then idle bus → romsel_q=00, lrom_dis_q=0, urom_dis_q=0, mode_q=0, no strobes for 100 cycles.
- OUT &DF00,&07 with WR low 3 cycles, SETTLE=1 → romsel_stb pulses once at edge k+3, romsel_q=07, MRER fields unchanged.
- OUT &7F00,&8C → mrer_stb once, lrom_dis_q=1, urom_dis_q=1, mode_q=00; then OUT &7F00,&89 → lrom_dis_q=0, urom_dis_q=1, mode_q=01; then OUT &7F00,&4C (palette) → no strobe, values unchanged.
- 1-cycle IORQ+WR glitch at &DFxx with SETTLE=2 → no strobe, romsel_q unchanged; same write held 6 cycles → exactly one strobe at edge k+4.
- WR held low 20 cycles at &DF00 with data &05 → single romsel_stb; back-to-back write of &0A after a 2-cycle release → second strobe, romsel_q=0A.
- reset_b pulsed low while FSM in COUNT → outputs return to reset values asynchronously, no strobe; next full write captures normally.
